// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU with a registered response channel.
// Optional feature: define ALU_ARB_RR_EN for round-robin tie breaking (default: requester 0 wins ties).
module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic [31:0] alu_srca,
    output logic [31:0] alu_srcb,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_sign,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_sign,
    output logic        rsp_err,
    input  logic        rsp_ready,
    output logic        dbg_state,
    output logic        dbg_last_grant
);

    // Handshake: a request transfers on a cycle where reqN_valid && reqN_ready; the
    // response transfers on a cycle where rsp_valid && rsp_ready.
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        last_grant;
    logic        accept;
    logic        grant;
    logic [3:0]  grant_op;
    logic        illegal_op;

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        grant      = 1'b0;
        grant_op   = 4'd0;
        illegal_op = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        alu_srca   = 32'd0;
        alu_srcb   = 32'd0;
        alu_ctrl   = 4'd0;

        if (!rst && (state_q == IDLE || rsp_ready) && (req0_valid || req1_valid)) begin
            accept = 1'b1;
        end

        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
            grant = ~last_grant;
`else
            grant = 1'b0;
`endif
        end else begin
            grant = req1_valid;
        end

        grant_op   = grant ? req1_op : req0_op;
        // 1010..1110 are reserved; they are accepted but never reach the ALU.
        illegal_op = (grant_op >= 4'b1010) && (grant_op != 4'b1111);

        if (accept) begin
            req0_ready = ~grant;
            req1_ready = grant;
            if (!illegal_op) begin
                alu_srca = grant ? req1_a : req0_a;
                alu_srcb = grant ? req1_b : req0_b;
                alu_ctrl = grant_op;
            end
            state_d = HOLD;
        end else if (state_q == HOLD && rsp_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_id     <= 1'b0;
            rsp_result <= 32'd0;
            rsp_zero   <= 1'b0;
            rsp_sign   <= 1'b0;
            rsp_err    <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            rsp_id     <= grant;
            last_grant <= grant;
            if (illegal_op) begin
                rsp_result <= 32'd0;
                rsp_zero   <= 1'b1;
                rsp_sign   <= 1'b0;
                rsp_err    <= 1'b1;
            end else begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
                rsp_sign   <= alu_sign;
                rsp_err    <= 1'b0;
            end
        end
    end

    assign rsp_valid      = (state_q == HOLD);
    assign dbg_state      = state_q;
    assign dbg_last_grant = last_grant;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; a small behavioural ALU stands in for the shared ALU.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_a, req0_b;
    logic [3:0]  req0_op;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_a, req1_b;
    logic [3:0]  req1_op;
    logic [31:0] alu_srca, alu_srcb;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero, alu_sign;
    logic        rsp_valid, rsp_id, rsp_zero, rsp_sign, rsp_err, rsp_ready;
    logic [31:0] rsp_result;
    logic        dbg_state, dbg_last_grant;

    int n_pass;
    int n_total;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_sign(rsp_sign), .rsp_err(rsp_err),
        .rsp_ready(rsp_ready),
        .dbg_state(dbg_state), .dbg_last_grant(dbg_last_grant)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared ALU
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_result = alu_srca + alu_srcb;
            4'b0001: alu_result = alu_srca - alu_srcb;
            4'b0010: alu_result = alu_srca & alu_srcb;
            4'b0011: alu_result = alu_srca | alu_srcb;
            4'b1111: alu_result = alu_srcb;
            default: alu_result = alu_srca ^ alu_srcb;
        endcase
        alu_zero = (alu_result == 32'd0);
        alu_sign = alu_result[31];
    end

    task automatic drive_idle();
        req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_op = 4'd0;
        req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_op = 4'd0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 4'b0001;
        req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd1; req1_op = 4'b0000;
        #1;
        n_total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready); else n_pass++;
        n_total++; if (alu_srca !== 32'd0 || alu_srcb !== 32'd0 || alu_ctrl !== 4'd0) $display("FAIL reset_alu got=%h/%h/%h exp=0/0/0", alu_srca, alu_srcb, alu_ctrl); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_err !== 1'b0 || rsp_zero !== 1'b0 || rsp_sign !== 1'b0) $display("FAIL reset_rsp_flags got=%b%b%b%b%b exp=00000", rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_sign); else n_pass++;
        n_total++; if (rsp_result !== 32'd0) $display("FAIL reset_rsp_result got=%h exp=0", rsp_result); else n_pass++;
        n_total++; if (dbg_last_grant !== 1'b1 || dbg_state !== 1'b0) $display("FAIL reset_state got=lg%b st%b exp=lg1 st0", dbg_last_grant, dbg_state); else n_pass++;
        @(negedge clk);
        drive_idle();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        @(negedge clk);
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 4'b0001;
        #1;
        n_total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL basic_ready got=%b%b exp=10", req0_ready, req1_ready); else n_pass++;
        n_total++; if (alu_srca !== 32'd5 || alu_srcb !== 32'd3 || alu_ctrl !== 4'b0001) $display("FAIL basic_alu got=%h/%h/%h exp=5/3/1", alu_srca, alu_srcb, alu_ctrl); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) $display("FAIL basic_rsp_vld_id got=%b/%b exp=1/0", rsp_valid, rsp_id); else n_pass++;
        n_total++; if (rsp_result !== 32'd2 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) $display("FAIL basic_rsp_data got=%h z%b e%b exp=2 z0 e0", rsp_result, rsp_zero, rsp_err); else n_pass++;
        @(negedge clk);
        drive_idle();
        @(posedge clk); #1;
        n_total++; if (rsp_valid !== 1'b0 || dbg_state !== 1'b0) $display("FAIL basic_drain got=v%b st%b exp=v0 st0", rsp_valid, dbg_state); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic        exp_g;
        logic [31:0] exp_r;
        // Fresh reset so last_grant starts at 1.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd1; req0_op = 4'b0000;
        req1_valid = 1'b1; req1_a = 32'd20; req1_b = 32'd2; req1_op = 4'b0000;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
            exp_g = (i % 2 == 1);
`else
            exp_g = 1'b0;
`endif
            exp_r = exp_g ? 32'd22 : 32'd11;
            #1;
            n_total++; if (req0_ready !== ~exp_g || req1_ready !== exp_g) $display("FAIL b2b_grant[%0d] got=%b%b exp_grant=%0d", i, req0_ready, req1_ready, exp_g); else n_pass++;
            @(posedge clk); #1;
            n_total++; if (rsp_valid !== 1'b1 || rsp_id !== exp_g || rsp_result !== exp_r) $display("FAIL b2b_rsp[%0d] got=v%b id%b %h exp=v1 id%b %h", i, rsp_valid, rsp_id, rsp_result, exp_g, exp_r); else n_pass++;
            n_total++; if (dbg_last_grant !== exp_g) $display("FAIL b2b_last_grant[%0d] got=%b exp=%b", i, dbg_last_grant, exp_g); else n_pass++;
            @(negedge clk);
        end
        drive_idle();
        @(posedge clk); #1;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL b2b_to_idle got=%b exp=0", rsp_valid); else n_pass++;
    endtask

    task automatic test_stall();
        logic [31:0] held;
        @(negedge clk);
        rsp_ready = 1'b0;  // ignored in IDLE
        req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd7; req1_op = 4'b0001;
        #1;
        n_total++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) $display("FAIL stall_accept got=%b%b exp=01", req0_ready, req1_ready); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b1) $display("FAIL stall_load got=v%b id%b %h z%b exp=v1 id1 0 z1", rsp_valid, rsp_id, rsp_result, rsp_zero); else n_pass++;
        held = rsp_result;
        @(negedge clk);
        drive_idle();
        req0_valid = 1'b1; req0_a = 32'd4; req0_b = 32'd2; req0_op = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || alu_ctrl !== 4'd0 || alu_srca !== 32'd0) $display("FAIL stall_blocked[%0d] got=%b%b ctrl%h a%h exp=00 ctrl0 a0", i, req0_ready, req1_ready, alu_ctrl, alu_srca); else n_pass++;
            @(posedge clk); #1;
            n_total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== held || rsp_zero !== 1'b1 || rsp_err !== 1'b0) $display("FAIL stall_hold[%0d] got=v%b id%b %h z%b e%b exp=v1 id1 0 z1 e0", i, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err); else n_pass++;
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        n_total++; if (req0_ready !== 1'b1) $display("FAIL stall_release_ready got=%b exp=1", req0_ready); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'd2) $display("FAIL stall_release_rsp got=v%b id%b %h exp=v1 id0 2", rsp_valid, rsp_id, rsp_result); else n_pass++;
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_illegal_op();
        logic [3:0] ops [4];
        logic       exp_err [4];
        ops[0] = 4'b1001; exp_err[0] = 1'b0;
        ops[1] = 4'b1010; exp_err[1] = 1'b1;
        ops[2] = 4'b1110; exp_err[2] = 1'b1;
        ops[3] = 4'b1111; exp_err[3] = 1'b0;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd4; req0_op = 4'b1100;
        #1;
        n_total++; if (req0_ready !== 1'b1 || alu_ctrl !== 4'd0 || alu_srca !== 32'd0 || alu_srcb !== 32'd0) $display("FAIL illegal_drive got=rdy%b ctrl%h a%h b%h exp=rdy1 0 0 0", req0_ready, alu_ctrl, alu_srca, alu_srcb); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (rsp_err !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b1 || rsp_sign !== 1'b0) $display("FAIL illegal_rsp got=e%b %h z%b s%b exp=e1 0 z1 s0", rsp_err, rsp_result, rsp_zero, rsp_sign); else n_pass++;
        @(negedge clk);
        // Legal subtract going negative: exercises sign and clears err.
        req0_a = 32'd3; req0_b = 32'd5; req0_op = 4'b0001;
        @(posedge clk); #1;
        n_total++; if (rsp_err !== 1'b0 || rsp_result !== 32'hFFFF_FFFE || rsp_sign !== 1'b1 || rsp_zero !== 1'b0) $display("FAIL legal_neg got=e%b %h s%b z%b exp=e0 fffffffe s1 z0", rsp_err, rsp_result, rsp_sign, rsp_zero); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req0_a = 32'd9; req0_b = 32'd4; req0_op = ops[i];
            @(posedge clk); #1;
            n_total++; if (rsp_err !== exp_err[i]) $display("FAIL op_boundary[%h] got=%b exp=%b", ops[i], rsp_err, exp_err[i]); else n_pass++;
        end
        @(negedge clk);
        drive_idle();
        @(posedge clk);
    endtask

    task automatic test_reset_in_hold();
        @(negedge clk);
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd8; req1_b = 32'd1; req1_op = 4'b0000;
        @(posedge clk); #1;
        n_total++; if (rsp_valid !== 1'b1) $display("FAIL rih_loaded got=%b exp=1", rsp_valid); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 4'b0000;
        #1;
        n_total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || alu_srca !== 32'd0) $display("FAIL rih_during_rst got=%b%b a%h exp=00 a0", req0_ready, req1_ready, alu_srca); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (rsp_valid !== 1'b0 || dbg_state !== 1'b0 || rsp_result !== 32'd0) $display("FAIL rih_discard got=v%b st%b %h exp=v0 st0 0", rsp_valid, dbg_state, rsp_result); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) $display("FAIL rih_first_tie got=%b%b exp=10", req0_ready, req1_ready); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (rsp_id !== 1'b0 || rsp_result !== 32'd2) $display("FAIL rih_first_rsp got=id%b %h exp=id0 2", rsp_id, rsp_result); else n_pass++;
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        rsp_ready = 1'b0;
        drive_idle();
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_illegal_op();
        test_reset_in_hold();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
